// File: rtl/regfile_pkg.sv
// Shared types, width limits and the byte-strobe merge helper for the
// multi-port register file.
package regfile_pkg;

    // Widest data path the merge helper supports; callers zero-extend into it.
    localparam int unsigned MAX_DATA_W = 512;
    localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

    typedef enum logic [0:0] {
        RF_INIT,
        RF_RUN
    } rf_state_e;

    // Replace each byte of old_word whose strobe is set with the same byte of new_word.
    function automatic logic [MAX_DATA_W-1:0] merge_bytes(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int k = 0; k < int'(MAX_STRB_W); k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sequencer: sweeps every entry once, then raises ready.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    rf_state_e         r_state;
    rf_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [ADDR_W-1:0] w_clr_idx_nxt;
    logic              r_ready;
    logic              w_ready_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= RF_INIT;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_ready_nxt   = r_ready;
        o_clr_we      = 1'b0;
        unique case (r_state)
            RF_INIT: begin
                // A reset edge must not land a clear write in the array.
                o_clr_we = i_rst_n;
                if (r_clr_idx == LAST_IDX) begin
                    w_state_nxt = RF_RUN;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
                end
            end
            RF_RUN: begin
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt   = RF_INIT;
                w_clr_idx_nxt = '0;
                w_ready_nxt   = 1'b0;
            end
        endcase
    end

    assign o_clr_addr = r_clr_idx;
    assign o_ready    = r_ready;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with byte-strobed writes,
// write-to-read bypass, optional hardwired zero entry and a post-reset clear sweep.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       NUM_REGS = 32,
    parameter int unsigned       NUM_RD   = 2,
    parameter bit                ZERO_REG = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    parameter int unsigned       ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [DATA_W/8-1:0]      i_wstrb,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic                     o_ready
);

    logic              w_ready;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;

    regfile_clr_seq #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clr_seq (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_ready    (w_ready)
    );

    assign o_ready = w_ready;

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    logic              w_waddr_ok;
    logic              w_ext_we;
    logic [DATA_W-1:0] w_old_word;
    logic [DATA_W-1:0] w_ext_word;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_word;

    // Writes to the zero entry or past the last entry are silently dropped.
    assign w_waddr_ok = (32'(i_waddr) < NUM_REGS) && !(ZERO_REG && (i_waddr == '0));
    assign w_ext_we   = i_rst_n && w_ready && i_we && w_waddr_ok && (|i_wstrb);
    assign w_old_word = w_waddr_ok ? r_mem[i_waddr] : '0;

    // Post-write word; shared by the array write port and every bypass path.
    assign w_ext_word = DATA_W'(merge_bytes(MAX_DATA_W'(w_old_word), MAX_DATA_W'(i_wdata),
                                            MAX_STRB_W'(i_wstrb)));

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = i_waddr;
        w_wr_word = w_ext_word;
        if (w_clr_we) begin
            w_wr_en   = 1'b1;
            w_wr_addr = w_clr_addr;
            w_wr_word = (ZERO_REG && (w_clr_addr == '0)) ? '0 : INIT_VAL;
        end else if (w_ext_we) begin
            w_wr_en = 1'b1;
        end
    end

    // Storage is deliberately not reset; the clear sweep initialises it.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_word;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_raddr;
        logic              w_rzero;
        logic              w_byp;
        logic [DATA_W-1:0] w_rdata;
        logic [DATA_W-1:0] r_rdata;

        assign w_raddr = i_rd_addr[g*ADDR_W +: ADDR_W];
        assign w_rzero = (32'(w_raddr) >= NUM_REGS) || (ZERO_REG && (w_raddr == '0));
        assign w_byp   = w_ext_we && (w_raddr == i_waddr);

        always_comb begin
            w_rdata = '0;
            if (w_ready && !w_rzero) begin
                w_rdata = w_byp ? w_ext_word : r_mem[w_raddr];
            end
        end

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_rdata <= '0;
            end else begin
                r_rdata <= w_rdata;
            end
        end

        assign o_rd_data[g*DATA_W +: DATA_W] = r_rdata;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: a 32x32 two-port instance and a
// 24-entry four-port instance with a non-zero INIT_VAL.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: 32 entries, 2 read ports, INIT_VAL 0.
    logic        a_rst_n;
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic [3:0]  a_wstrb;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic        a_ready;

    // Instance B: 24 entries, 4 read ports, INIT_VAL 0xA5.
    logic         b_rst_n;
    logic         b_we;
    logic [4:0]   b_waddr;
    logic [31:0]  b_wdata;
    logic [3:0]   b_wstrb;
    logic [19:0]  b_rd_addr;
    logic [127:0] b_rd_data;
    logic         b_ready;

    localparam logic [31:0] B_INIT = 32'h0000_00A5;

    regfile_mp #(
        .DATA_W   (32),
        .NUM_REGS (32),
        .NUM_RD   (2),
        .ZERO_REG (1'b1),
        .INIT_VAL (32'h0)
    ) u_dut_a (
        .i_clk     (clk),
        .i_rst_n   (a_rst_n),
        .i_we      (a_we),
        .i_waddr   (a_waddr),
        .i_wdata   (a_wdata),
        .i_wstrb   (a_wstrb),
        .i_rd_addr (a_rd_addr),
        .o_rd_data (a_rd_data),
        .o_ready   (a_ready)
    );

    regfile_mp #(
        .DATA_W   (32),
        .NUM_REGS (24),
        .NUM_RD   (4),
        .ZERO_REG (1'b1),
        .INIT_VAL (B_INIT)
    ) u_dut_b (
        .i_clk     (clk),
        .i_rst_n   (b_rst_n),
        .i_we      (b_we),
        .i_waddr   (b_waddr),
        .i_wdata   (b_wdata),
        .i_wstrb   (b_wstrb),
        .i_rd_addr (b_rd_addr),
        .o_rd_data (b_rd_data),
        .o_ready   (b_ready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic b_write(input logic [4:0] addr, input logic [31:0] data);
        b_we    = 1'b1;
        b_waddr = addr;
        b_wdata = data;
        b_wstrb = 4'hF;
        tick();
        b_we    = 1'b0;
    endtask

    initial begin
        a_rst_n = 1'b0; a_we = 1'b0; a_waddr = '0; a_wdata = '0; a_wstrb = '0; a_rd_addr = '0;
        b_rst_n = 1'b0; b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_wstrb = '0; b_rd_addr = '0;
        tick();
        tick();
        chk("a_reset_ready", 128'(a_ready), 128'(1'b0));
        chk("a_reset_rdata", 128'(a_rd_data), 128'h0);
        chk("b_reset_ready", 128'(b_ready), 128'(1'b0));
        chk("b_reset_rdata", b_rd_data, 128'h0);

        // Clear sweep with an external write attempt to r5 held throughout.
        a_rst_n   = 1'b1;
        a_we      = 1'b1;
        a_waddr   = 5'd5;
        a_wdata   = 32'hFFFF_FFFF;
        a_wstrb   = 4'hF;
        a_rd_addr = {5'd5, 5'd5};
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk($sformatf("a_init_ready[%0d]", k), 128'(a_ready), 128'(k == 32));
            chk($sformatf("a_init_rdata[%0d]", k), 128'(a_rd_data), 128'h0);
            if (k == 32) a_we = 1'b0;
        end
        tick();
        chk("a_r5_after_init", 128'(a_rd_data[31:0]), 128'h0);

        // Byte strobes, including bypass of a partial-strobe write.
        a_we      = 1'b1;
        a_waddr   = 5'd3;
        a_wdata   = 32'h1122_3344;
        a_wstrb   = 4'hF;
        a_rd_addr = {5'd0, 5'd3};
        tick();
        chk("a_byp_full_r3", 128'(a_rd_data[31:0]), 128'h1122_3344);
        chk("a_zero_port1", 128'(a_rd_data[63:32]), 128'h0);
        a_wdata = 32'hAABB_CCDD;
        a_wstrb = 4'b0101;
        tick();
        chk("a_byp_strb_r3", 128'(a_rd_data[31:0]), 128'h11BB_33DD);
        a_we = 1'b0;
        tick();
        chk("a_strb_r3", 128'(a_rd_data[31:0]), 128'h11BB_33DD);
        a_we    = 1'b1;
        a_wdata = 32'h0;
        a_wstrb = 4'h0;
        tick();
        a_we = 1'b0;
        tick();
        chk("a_nostrb_r3", 128'(a_rd_data[31:0]), 128'h11BB_33DD);

        // Same-cycle bypass on both ports.
        a_we      = 1'b1;
        a_waddr   = 5'd7;
        a_wdata   = 32'hDEAD_BEEF;
        a_wstrb   = 4'hF;
        a_rd_addr = {5'd7, 5'd7};
        tick();
        chk("a_byp_p0", 128'(a_rd_data[31:0]), 128'hDEAD_BEEF);
        chk("a_byp_p1", 128'(a_rd_data[63:32]), 128'hDEAD_BEEF);
        a_we = 1'b0;
        tick();
        chk("a_r7_stored", 128'(a_rd_data[63:32]), 128'hDEAD_BEEF);

        // Reset mid-operation and again mid-INIT at clr_idx 10.
        a_we      = 1'b1;
        a_waddr   = 5'd9;
        a_wdata   = 32'h0000_CAFE;
        a_rd_addr = {5'd7, 5'd9};
        tick();
        a_we = 1'b0;
        tick();
        chk("a_r9_cafe", 128'(a_rd_data[31:0]), 128'hCAFE);
        a_rst_n = 1'b0;
        tick();
        chk("a_rst_run_ready", 128'(a_ready), 128'(1'b0));
        a_rst_n = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("a_part_init_ready", 128'(a_ready), 128'(1'b0));
        a_rst_n = 1'b0;
        tick();
        chk("a_rst_init_rdata", 128'(a_rd_data), 128'h0);
        a_rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk($sformatf("a_reinit_ready[%0d]", k), 128'(a_ready), 128'(k == 32));
        end
        tick();
        chk("a_r9_cleared", 128'(a_rd_data[31:0]), 128'h0);
        chk("a_r7_cleared", 128'(a_rd_data[63:32]), 128'h0);

        // Instance B: clear sweep of 24 entries.
        b_rst_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            chk($sformatf("b_init_ready[%0d]", k), 128'(b_ready), 128'(k == 24));
        end
        for (int k = 1; k <= 4; k++) b_write(5'(k), 32'(k));

        // Dropped writes to the zero entry and out of range, observed via bypass.
        b_rd_addr = {5'd0, 5'd0, 5'd30, 5'd0};
        b_write(5'd0, 32'h5);
        chk("b_r0_byp", 128'(b_rd_data[31:0]), 128'h0);
        b_write(5'd30, 32'h5);
        chk("b_r30_byp", 128'(b_rd_data[63:32]), 128'h0);

        // Four ports, one-cycle latency.
        b_rd_addr = {5'd1, 5'd2, 5'd3, 5'd4};
        #1;
        chk("b_mp_pre", b_rd_data, 128'h0);
        tick();
        chk("b_mp", b_rd_data, {32'd1, 32'd2, 32'd3, 32'd4});
        b_rd_addr = {5'd10, 5'd23, 5'd30, 5'd0};
        tick();
        chk("b_mix", b_rd_data, {B_INIT, B_INIT, 32'h0, 32'h0});
        for (int i = 1; i <= 23; i++) begin
            b_rd_addr = {5'(i), 5'(i), 5'(i), 5'(i)};
            tick();
            chk($sformatf("b_r%0d_p0", i), 128'(b_rd_data[31:0]), 128'((i <= 4) ? 32'(i) : B_INIT));
            chk($sformatf("b_r%0d_p3", i), 128'(b_rd_data[127:96]),
                128'((i <= 4) ? 32'(i) : B_INIT));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
